// File: rtl/uart_pcfg.sv
// AXI4-Stream UART with runtime frame format (5..DATA_WIDTH bits, parity, 1/2 stop)
// and a first-word fall-through RX FIFO carrying a per-word parity flag.
module uart_pcfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  input  logic                             rxd,
  output logic                             txd,
  output logic                             tx_busy,
  output logic                             rx_busy,
  output logic                             rx_overrun_error,
  output logic                             rx_frame_error,
  output logic                             rx_parity_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_fifo_count,
  input  logic [15:0]                      prescale,
  input  logic [3:0]                       data_bits,
  input  logic [1:0]                       parity_mode,
  input  logic                             stop_bits
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PAR  = 3'd3, S_STOP  = 3'd4, S_WAIT = 3'd5;

  logic [15:0]           w_pre;
  logic [18:0]           w_per;
  logic [3:0]            w_nb;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_pen, w_odd;

  assign w_pre = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_per = {w_pre, 3'b000};
  assign w_pen = (parity_mode == 2'd1) || (parity_mode == 2'd2);
  assign w_odd = (parity_mode == 2'd2);

  always_comb begin
    if (data_bits < 4'd5)                   w_nb = 4'd5;
    else if (data_bits > 4'(DATA_WIDTH))    w_nb = 4'(DATA_WIDTH);
    else                                    w_nb = data_bits;
    w_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_mask[i] = (4'(i) < w_nb);
  end

  // ---------------- TX ----------------
  logic [2:0]            r_tx_st;
  logic                  r_tx_rdy, r_txd, r_tx_busy, r_tx_pen, r_tx_par, r_tx_stop2;
  logic [18:0]           r_tx_cnt, r_tx_per;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [3:0]            r_tx_idx, r_tx_nb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_st <= S_IDLE; r_tx_rdy <= 1'b0; r_txd <= 1'b1; r_tx_busy <= 1'b0;
      r_tx_pen <= 1'b0; r_tx_par <= 1'b0; r_tx_stop2 <= 1'b0;
      r_tx_cnt <= '0; r_tx_per <= '0; r_tx_sh <= '0; r_tx_idx <= '0; r_tx_nb <= '0;
    end else if (r_tx_st == S_IDLE) begin
      r_tx_rdy <= 1'b1;
      if (s_axis_tvalid && r_tx_rdy) begin
        r_tx_rdy   <= 1'b0;
        r_tx_busy  <= 1'b1;
        r_txd      <= 1'b0;
        r_tx_st    <= S_START;
        r_tx_cnt   <= w_per - 19'd1;
        r_tx_per   <= w_per;
        r_tx_sh    <= s_axis_tdata & w_mask;
        r_tx_nb    <= w_nb;
        r_tx_pen   <= w_pen;
        r_tx_par   <= (^(s_axis_tdata & w_mask)) ^ w_odd;
        r_tx_stop2 <= stop_bits;
        r_tx_idx   <= '0;
      end
    end else if (r_tx_cnt != 19'd0) begin
      r_tx_cnt <= r_tx_cnt - 19'd1;
    end else begin
      r_tx_cnt <= r_tx_per - 19'd1;
      case (r_tx_st)
        S_START: begin
          r_tx_st <= S_DATA; r_txd <= r_tx_sh[0]; r_tx_sh <= r_tx_sh >> 1;
        end
        S_DATA: begin
          if (r_tx_idx == r_tx_nb - 4'd1) begin
            r_tx_st <= r_tx_pen ? S_PAR : S_STOP;
            r_txd   <= r_tx_pen ? r_tx_par : 1'b1;
          end else begin
            r_tx_idx <= r_tx_idx + 4'd1; r_txd <= r_tx_sh[0]; r_tx_sh <= r_tx_sh >> 1;
          end
        end
        S_PAR: begin
          r_tx_st <= S_STOP; r_txd <= 1'b1;
        end
        S_STOP: begin
          // ready goes high together with the end of the last stop bit
          if (r_tx_stop2) r_tx_stop2 <= 1'b0;
          else begin r_tx_st <= S_IDLE; r_tx_busy <= 1'b0; r_tx_rdy <= 1'b1; end
        end
        default: r_tx_st <= S_IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_tx_rdy;
  assign txd           = r_txd;
  assign tx_busy       = r_tx_busy;

  // ---------------- RX ----------------
  logic                  r_rx_s1, r_rx_s2, r_rx_s3;
  logic [2:0]            r_rx_st;
  logic [18:0]           r_rx_cnt, r_rx_per;
  logic [3:0]            r_rx_idx, r_rx_nb;
  logic                  r_rx_pen, r_rx_odd, r_rx_pbit, r_rx_busy, r_ferr, r_perr, r_ovr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  w_fall, w_push, w_pmis;

  assign w_fall = r_rx_s3 & ~r_rx_s2;
  assign w_push = (r_rx_st == S_STOP) && (r_rx_cnt == 19'd0) && r_rx_s2;
  assign w_pmis = r_rx_pen && (r_rx_pbit != ((^r_rx_data) ^ r_rx_odd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
      r_rx_st <= S_IDLE; r_rx_cnt <= '0; r_rx_per <= '0; r_rx_idx <= '0; r_rx_nb <= '0;
      r_rx_pen <= 1'b0; r_rx_odd <= 1'b0; r_rx_pbit <= 1'b0; r_rx_busy <= 1'b0;
      r_ferr <= 1'b0; r_perr <= 1'b0; r_rx_data <= '0;
    end else begin
      r_rx_s1 <= rxd; r_rx_s2 <= r_rx_s1; r_rx_s3 <= r_rx_s2;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      case (r_rx_st)
        S_IDLE: if (w_fall) begin
          r_rx_st   <= S_START;
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= {1'b0, w_pre, 2'b00} - 19'd1;
          r_rx_per  <= w_per;
          r_rx_nb   <= w_nb;
          r_rx_pen  <= w_pen;
          r_rx_odd  <= w_odd;
          r_rx_data <= '0;
          r_rx_idx  <= '0;
        end
        S_WAIT: if (r_rx_s2) begin r_rx_st <= S_IDLE; r_rx_busy <= 1'b0; end
        default: begin
          if (r_rx_cnt != 19'd0) r_rx_cnt <= r_rx_cnt - 19'd1;
          else begin
            r_rx_cnt <= r_rx_per - 19'd1;
            case (r_rx_st)
              S_START: if (r_rx_s2) begin r_rx_st <= S_IDLE; r_rx_busy <= 1'b0; end
                       else r_rx_st <= S_DATA;
              S_DATA: begin
                r_rx_data <= r_rx_data | (DATA_WIDTH'(r_rx_s2) << r_rx_idx);
                if (r_rx_idx == r_rx_nb - 4'd1) r_rx_st <= r_rx_pen ? S_PAR : S_STOP;
                else r_rx_idx <= r_rx_idx + 4'd1;
              end
              S_PAR: begin r_rx_pbit <= r_rx_s2; r_rx_st <= S_STOP; end
              S_STOP: begin
                // leave mid-stop on a good stop; a low stop (incl. break) waits for idle line
                if (r_rx_s2) begin r_rx_st <= S_IDLE; r_rx_busy <= 1'b0; r_perr <= w_pmis; end
                else begin r_ferr <= 1'b1; r_rx_st <= S_WAIT; end
              end
              default: begin r_rx_st <= S_IDLE; r_rx_busy <= 1'b0; end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_cnt;
  logic                w_full, w_pop, w_wr;

  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) && m_axis_tready;
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0; r_rp <= '0; r_cnt <= '0; r_ovr <= 1'b0;
    end else begin
      r_ovr <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wp] <= {w_pmis, r_rx_data};
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign m_axis_tdata     = r_mem[r_rp][DATA_WIDTH-1:0];
  assign m_axis_tuser     = r_mem[r_rp][DATA_WIDTH];
  assign m_axis_tvalid    = (r_cnt != '0);
  assign rx_fifo_count    = r_cnt;
  assign rx_busy          = r_rx_busy;
  assign rx_frame_error   = r_ferr;
  assign rx_parity_error  = r_perr;
  assign rx_overrun_error = r_ovr;
endmodule

// File: tb/tb_uart_pcfg.sv
// Bench for uart_pcfg: frame-format table over loopback, injected RX corner cases,
// FIFO overrun, reset abort, and randomized RX frames against a queue model.
module tb_uart_pcfg;
  logic       clk = 0, rst = 1;
  logic [7:0] s_axis_tdata = 0;
  logic       s_axis_tvalid = 0, s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tuser, m_axis_tvalid, m_axis_tready = 0;
  logic       txd, tx_busy, rx_busy, rx_overrun_error, rx_frame_error, rx_parity_error;
  logic [2:0] rx_fifo_count;
  logic [15:0] prescale = 1;
  logic [3:0] data_bits = 8;
  logic [1:0] parity_mode = 0;
  logic       stop_bits = 0;
  logic       r_loop = 0, r_rxd = 1, w_rxd;

  assign w_rxd = r_loop ? txd : r_rxd;
  always #5 clk = ~clk;

  uart_pcfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .rxd(w_rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
    .rx_parity_error(rx_parity_error), .rx_fifo_count(rx_fifo_count),
    .prescale(prescale), .data_bits(data_bits), .parity_mode(parity_mode), .stop_bits(stop_bits));

  int n_chk = 0, n_pass = 0;
  int c_ferr = 0, c_perr = 0, c_ovr = 0;

  always @(negedge clk) begin
    if (rx_frame_error)   c_ferr++;
    if (rx_parity_error)  c_perr++;
    if (rx_overrun_error) c_ovr++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic int clampnb(input int nb);
    return (nb < 5) ? 5 : (nb > 8) ? 8 : nb;
  endfunction

  // Expected line levels of one frame, one entry per bit period.
  function automatic int build(input logic [7:0] w, input int nb, input int pm, input int sb,
                               input bit badpar, output bit b[16]);
    int n = 0;
    bit p = 0;
    for (int i = 0; i < 16; i++) b[i] = 1;
    b[n] = 0; n++;
    for (int i = 0; i < nb; i++) begin b[n] = w[i]; p ^= w[i]; n++; end
    if (pm == 1 || pm == 2) begin b[n] = p ^ (pm == 2) ^ badpar; n++; end
    return n + 1 + sb;
  endfunction

  task automatic set_cfg(input int dbits, input int pm, input int sb, input int pre);
    data_bits = 4'(dbits); parity_mode = 2'(pm); stop_bits = sb[0]; prescale = 16'(pre);
  endtask

  task automatic tx_check(input string nm, input logic [7:0] w, input int dbits, input int pm,
                          input int sb, input int pre, input int F);
    bit b[16];
    int n, per, t, bad_txd, bad_ctl;
    per = 8 * ((pre == 0) ? 1 : pre);
    n = build(w, clampnb(dbits), pm, sb, 1'b0, b);
    @(negedge clk);
    set_cfg(dbits, pm, sb, pre);
    t = 0;
    while (!s_axis_tready && t < 2000) begin @(negedge clk); t++; end
    chk({nm, "_rdy"}, s_axis_tready, 1);
    s_axis_tdata = w; s_axis_tvalid = 1;
    @(posedge clk); #1;
    s_axis_tvalid = 0;
    bad_txd = 0; bad_ctl = 0;
    for (int c = 0; c < F; c++) begin
      if (c / per >= n || txd !== b[c / per]) bad_txd++;
      if (s_axis_tready !== 1'b0 || tx_busy !== 1'b1) bad_ctl++;
      @(posedge clk); #1;
    end
    chk({nm, "_txd_bad_cycles"}, bad_txd, 0);
    chk({nm, "_busy_low_rdy_cycles"}, bad_ctl, 0);
    chk({nm, "_rdy_after"}, {tx_busy, s_axis_tready, txd}, 3'b011);
  endtask

  task automatic drive_frame(input logic [7:0] w, input int dbits, input int pm, input int sb,
                             input int pre, input bit badpar, input bit popstop);
    bit b[16];
    int n, per;
    per = 8 * ((pre == 0) ? 1 : pre);
    @(negedge clk);
    set_cfg(dbits, pm, sb, pre);
    n = build(w, clampnb(dbits), pm, sb, badpar, b);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < per; c++) begin
        r_rxd = b[k];
        m_axis_tready = popstop && (k == n - 1 - sb) && (c == 0);
        @(negedge clk);
      end
    m_axis_tready = 0; r_rxd = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input string nm, input logic [7:0] ed, input logic eu);
    @(negedge clk);
    chk({nm, "_vld"}, m_axis_tvalid, 1);
    chk({nm, "_data"}, m_axis_tdata, ed);
    chk({nm, "_user"}, m_axis_tuser, eu);
    m_axis_tready = 1;
    @(negedge clk);
    m_axis_tready = 0;
  endtask

  typedef struct {
    logic [7:0] w;
    int nb, pm, sb, pre, F;
    logic [7:0] rx;
  } tv_t;

  typedef struct { logic [7:0] d; logic u; } rxw_t;

  initial begin
    tv_t tv[6];
    rxw_t q[$];
    rxw_t e;
    int f0, p0, o0, exp_ovr, exp_perr, nb, pm;
    logic [7:0] w;
    bit bp;

    tv[0] = '{8'hA5,  8, 0, 0, 1,  80, 8'hA5};
    tv[1] = '{8'h53,  7, 1, 1, 2, 176, 8'h53};
    tv[2] = '{8'hFF,  3, 2, 0, 1,  64, 8'h1F};
    tv[3] = '{8'hC3, 15, 1, 1, 0,  96, 8'hC3};
    tv[4] = '{8'h2A,  6, 3, 0, 1,  64, 8'h2A};
    tv[5] = '{8'h96,  8, 2, 1, 3, 288, 8'h96};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mdata_user", {m_axis_tuser, m_axis_tdata}, 0);
    chk("rst_busy_err", {tx_busy, rx_busy, rx_overrun_error, rx_frame_error, rx_parity_error}, 0);
    chk("rst_count", rx_fifo_count, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_tready_rise", s_axis_tready, 1);

    // frame-format table over loopback
    r_loop = 1;
    for (int i = 0; i < 6; i++) begin
      tx_check($sformatf("tv%0d", i), tv[i].w, tv[i].nb, tv[i].pm, tv[i].sb, tv[i].pre, tv[i].F);
      pop_check($sformatf("tv%0d_rx", i), tv[i].rx, 1'b0);
    end
    r_loop = 0;
    repeat (4) @(negedge clk);
    chk("tv_count_empty", rx_fifo_count, 0);

    // 8O1 with wrong parity bit
    p0 = c_perr;
    drive_frame(8'h0F, 8, 2, 0, 1, 1'b1, 1'b0);
    chk("perr_pulses", c_perr - p0, 1);
    pop_check("perr_word", 8'h0F, 1'b1);

    // break, then a clean frame
    f0 = c_ferr; p0 = c_perr;
    set_cfg(8, 0, 0, 1);
    r_rxd = 0;
    repeat (160) @(negedge clk);
    r_rxd = 1;
    repeat (20) @(negedge clk);
    chk("brk_ferr_pulses", c_ferr - f0, 1);
    chk("brk_no_word", rx_fifo_count, 0);
    drive_frame(8'h3C, 8, 0, 0, 1, 1'b0, 1'b0);
    pop_check("brk_next", 8'h3C, 1'b0);

    // overrun: 5 frames into 4 entries
    o0 = c_ovr;
    for (int i = 1; i <= 5; i++) drive_frame(8'(i), 8, 0, 0, 1, 1'b0, 1'b0);
    chk("ovr_count", rx_fifo_count, 4);
    chk("ovr_pulses", c_ovr - o0, 1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_pop%0d", i), 8'(i), 1'b0);
    chk("ovr_drained", rx_fifo_count, 0);

    // pop while the 5th frame is arriving keeps it
    o0 = c_ovr;
    for (int i = 1; i <= 5; i++) drive_frame(8'(i), 8, 0, 0, 1, 1'b0, i == 5);
    chk("pop5_count", rx_fifo_count, 4);
    chk("pop5_no_ovr", c_ovr - o0, 0);
    for (int i = 2; i <= 5; i++) pop_check($sformatf("pop5_pop%0d", i), 8'(i), 1'b0);

    // randomized RX frames against a queue model
    o0 = c_ovr; p0 = c_perr; exp_ovr = 0; exp_perr = 0;
    for (int k = 0; k < 24; k++) begin
      w  = 8'($urandom);
      nb = $urandom_range(15, 0);
      pm = $urandom_range(3, 0);
      bp = ($urandom_range(3, 0) == 0);
      drive_frame(w, nb, pm, $urandom_range(1, 0), $urandom_range(2, 0), bp, 1'b0);
      e.d = w & 8'((1 << clampnb(nb)) - 1);
      e.u = bp && (pm == 1 || pm == 2);
      if (e.u) exp_perr++;
      if (q.size() == 4) exp_ovr++;
      else q.push_back(e);
      if ($urandom_range(1, 0) == 1 && q.size() > 0) begin
        e = q.pop_front();
        pop_check($sformatf("rnd%0d", k), e.d, e.u);
      end
    end
    chk("rnd_count", rx_fifo_count, q.size());
    chk("rnd_ovr", c_ovr - o0, exp_ovr);
    chk("rnd_perr", c_perr - p0, exp_perr);
    while (q.size() > 0) begin
      e = q.pop_front();
      pop_check("rnd_drain", e.d, e.u);
    end

    // reset mid-TX-frame with a word waiting in the FIFO
    drive_frame(8'h77, 8, 0, 0, 1, 1'b0, 1'b0);
    chk("rstmid_pre_count", rx_fifo_count, 1);
    @(negedge clk);
    s_axis_tdata = 8'h00; s_axis_tvalid = 1;
    @(posedge clk); #1;
    s_axis_tvalid = 0;
    repeat (30) @(negedge clk);
    chk("rstmid_txd_low", txd, 0);
    rst = 1;
    #1;
    chk("rstmid_txd", txd, 1);
    chk("rstmid_ctl", {tx_busy, s_axis_tready, m_axis_tvalid}, 0);
    chk("rstmid_count", rx_fifo_count, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("rstmid_rdy", s_axis_tready, 1);
    repeat (100) @(negedge clk);
    chk("rstmid_txd_idle", txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_pcfg.md
# uart_pcfg

Parametrised AXI4-Stream UART with runtime-selectable frame format (5–DATA_WIDTH data bits, none/even/odd parity, 1 or 2 stop bits) and an RX elastic FIFO. It replaces the fixed 8N1 UART at the host-link boundary: the SHA/control logic talks to it over AXI4-Stream, and it drives `txd` and receives on `rxd`. Adds per-word parity status, an occupancy count and break-safe resynchronisation.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame (5..9).
- FIFO_DEPTH, 4: RX FIFO entries; power of two, ≥2.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  TX word; bits at and above `data_bits` are ignored.
- s_axis_tvalid  in  1 / s_axis_tready  out  1  TX handshake.
- m_axis_tdata  out  DATA_WIDTH  RX word, zero-extended above `data_bits`.
- m_axis_tuser  out  1  parity error for the word at head.
- m_axis_tvalid  out  1 / m_axis_tready  in  1  RX handshake.
- rxd  in  1  serial in (asynchronous) / txd  out  1  serial out.
- tx_busy, rx_busy  out  1  frame in progress.
- rx_overrun_error, rx_frame_error, rx_parity_error  out  1  one-cycle pulses.
- rx_fifo_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- prescale  in  16  bit period = 8·prescale cycles; 0 treated as 1.
- data_bits  in  4  5..DATA_WIDTH; out-of-range values clamp to the nearest legal value.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 none.
- stop_bits  in  1  0: one stop bit, 1: two stop bits.

## Operation
- Reset values:
  - `txd`=1, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0.
  - All busy/error outputs 0, `rx_fifo_count`=0.
  - The RX synchroniser resets to 1.
  - `s_axis_tready` rises on the first clk edge after `rst` falls.
- Config is latched at frame start (TX accept, RX start detect). Changes mid-frame do not affect that frame.
- TX FSM: IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE.
  - IDLE: `tready`=1. On tvalid&tready, latch word; next cycle `tready`=0, `tx_busy`=1, `txd`=0.
  - DATA: LSB first, `data_bits` bits.
  - PARITY: XOR of data bits (even) or its inverse (odd).
  - STOP: 1 or 2 bit periods high.
- RX path: 2-flop synchroniser on `rxd`.
- RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE, with an extra WAIT_HIGH state.
  - IDLE: a falling edge of the synchronised input enters START; `rx_busy`=1.
  - START sample at 4·prescale cycles; if high, this is a false start: back to IDLE, no error.
  - Subsequent samples every 8·prescale cycles.
  - Parity mismatch sets the stored `tuser` and pulses `rx_parity_error` at the stop sample. The word is still delivered.
  - Only the first stop bit is checked.
  - Stop sample low: pulse `rx_frame_error`, discard word, go to WAIT_HIGH until the input is 1, then IDLE. This covers break.
  - Stop sample high: push word and go to IDLE immediately (mid-stop), so two stop bits are tolerated.
- FIFO is first-word fall-through; `m_axis_tvalid` = count≠0.
  - Push when full with no pop: word dropped, `rx_overrun_error` pulses, FIFO contents unchanged.
  - Push when full with a pop in the same cycle: accepted, count unchanged.
  - Push/pop on empty: push only (no bypass).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- TX frame length F = (1 + N + P + S)·8·prescale cycles.
  - N = data bits, P = 1 if parity else 0, S = stop bits.
- TX timing:
  - `txd` falls one cycle after the accept edge.
  - `tx_busy` stays high for F cycles.
  - `tready` reasserts in the cycle after the last stop bit ends.
  - Minimum accept-to-accept spacing is F+1 cycles.
- RX timing:
  - Start detect lags the `rxd` edge by 2–3 cycles (synchroniser).
  - A good word appears on m_axis (and count increments) one cycle after the stop sample.
  - Error pulses occur in that same cycle.
- Pop takes effect on the tvalid&tready edge; the next head is visible the following cycle.
- `rst` asserted mid-frame: both FSMs abort to reset values immediately, the FIFO is emptied, and `txd`=1 with no partial frame.

## Test plan
- 8N1, prescale=1: send 0xA5 → `txd` = 0,1,0,1,0,0,1,0,1,1, 8 cycles each; `tready` low for 80 cycles.
- 7E2, prescale=2: loop `txd` to `rxd` and send 0x53 → parity bit 0, frame 176 cycles; RX outputs 0x53, `tuser`=0.
- 8O1: inject 0x0F with even parity bit → RX word 0x0F, `tuser`=1, one `rx_parity_error` pulse.
- Hold `rxd` low for 20 bit periods (break) → one `rx_frame_error`, no word; a following 0x3C frame is received correctly.
- FIFO_DEPTH=4, `m_axis_tready`=0, 5 frames 0x01..0x05 → count=4, one overrun; pops return 0x01..0x04. Repeat with pop on the 5th push → 0x05 kept.
- Assert `rst` mid-TX-frame → `txd`=1 immediately; after release `tready`=1 next cycle, count=0.
